// File: rtl/dot_acc.sv
// dot_acc: sums DIM consecutive products into one result-matrix element and
// presents each element on a valid/ready output tagged with its row/column,
// walking a DIM x DIM matrix in row-major order.
module dot_acc #(
    parameter int unsigned DIM = 3,
    parameter int unsigned PW  = 16,
    parameter int unsigned AW  = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [PW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [AW-1:0] out_data,
    output logic [3:0]    out_row,
    output logic [3:0]    out_col,
    output logic          out_last,
    input  logic          out_ready
);

    localparam int unsigned IW = 4;
    localparam logic [IW-1:0] IDX_MAX = IW'(DIM - 1);

    logic [AW-1:0] acc_q, acc_d;
    logic [IW-1:0] k_q, k_d;
    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;
    logic [AW-1:0] out_data_q, out_data_d;
    logic [IW-1:0] out_row_q, out_row_d;
    logic [IW-1:0] out_col_q, out_col_d;
    logic          out_last_q, out_last_d;
    logic          out_valid_q, out_valid_d;

    logic          last_term;
    logic          accept;
    logic [AW-1:0] sum;

    // Final term may only be taken once the previous element has a home.
    assign last_term = (k_q == IDX_MAX);
    assign in_ready  = !(last_term && out_valid_q && !out_ready);
    assign accept    = in_valid && in_ready;
    assign sum       = acc_q + AW'(in_data);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;

    // Next-state: accumulate, emit element, drain, and clear (clear wins).
    always_comb begin
        acc_d       = acc_q;
        k_d         = k_q;
        row_d       = row_q;
        col_d       = col_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (!last_term) begin
                acc_d = sum;
                k_d   = k_q + IW'(1);
            end else begin
                out_data_d  = sum;
                out_row_d   = row_q;
                out_col_d   = col_q;
                out_last_d  = (row_q == IDX_MAX) && (col_q == IDX_MAX);
                out_valid_d = 1'b1;
                acc_d       = '0;
                k_d         = '0;
                if (col_q == IDX_MAX) begin
                    col_d = '0;
                    row_d = (row_q == IDX_MAX) ? '0 : row_q + IW'(1);
                end else begin
                    col_d = col_q + IW'(1);
                end
            end
        end

        if (clr) begin
            acc_d       = '0;
            k_d         = '0;
            row_d       = '0;
            col_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            k_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            k_q         <= k_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
